// File: rtl/branch_pkg.sv
// Shared types for the branch resolver: prediction record, FSM states, default depth.
package branch_pkg;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } br_state_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order prediction FIFO with a synchronous flush. DEPTH must be a power of 2,
// so the pointers wrap by plain truncation.
module pred_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  pred_entry_t              wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output pred_entry_t              head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  pred_entry_t   mem [DEPTH];

  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// Matches EX-stage branch outcomes against queued IF-stage predictions,
// trains the predictor, redirects fetch on mispredicts and keeps statistics.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_push,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        pred_full,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        update_en,
  output logic [31:0] update_pc,
  output logic        update_taken,
  output logic [31:0] update_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count,
  output logic        err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  br_state_t   state;
  pred_entry_t head;
  pred_entry_t wr_entry;
  logic [CW-1:0] occ;
  logic fifo_empty, run, resolve, pop, push_ok;
  logic pc_mismatch, dir_wrong, mispredict;

  assign wr_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  assign fifo_empty  = (occ == '0);
  assign pred_full   = (occ == CW'(FIFO_DEPTH));
  assign run         = (state == ST_RUN);
  assign resolve     = run && res_valid;
  assign pop         = resolve && !fifo_empty;
  assign pc_mismatch = pop && (head.pc != res_pc);
  assign dir_wrong   = (head.taken != res_taken) ||
                       (head.taken && res_taken && (head.target != res_target));
  assign mispredict  = pop && (pc_mismatch || dir_wrong);
  // A full FIFO still takes a push when the head leaves in the same cycle;
  // a mispredict flush discards it regardless.
  assign push_ok     = run && pred_push && (!pred_full || pop);

  pred_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_ok),
    .wr_data (wr_entry),
    .pop     (pop),
    .flush   (mispredict),
    .head    (head),
    .count   (occ)
  );

  // FSM plus registered training, redirect, statistics and sticky error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_RUN;
      update_en        <= 1'b0;
      update_pc        <= '0;
      update_taken     <= 1'b0;
      update_target    <= '0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      err              <= 1'b0;
    end else begin
      state          <= (run && mispredict) ? ST_FLUSH : ST_RUN;
      update_en      <= resolve;
      redirect_valid <= mispredict;
      if (resolve) begin
        update_pc     <= res_pc;
        update_taken  <= res_taken;
        update_target <= res_target;
        branch_count  <= branch_count + 32'd1;
      end
      if (mispredict) begin
        mispredict_count <= mispredict_count + 32'd1;
        redirect_pc      <= res_taken ? res_target : res_pc + 32'd4;
      end
      if (resolve && (fifo_empty || pc_mismatch)) err <= 1'b1;
    end
  end

endmodule
